// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the FP unit: field widths, bias, special encodings,
// FSM state type and operand classification used by both the divider and the multiplier.
package fp16_pkg;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned BIAS  = 15;
    localparam int unsigned QW    = 13;
    localparam int unsigned EW    = 7;
    localparam int unsigned CNT_W = $clog2(QW);

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_INF  = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp16_t;

    // Subnormal encodings (exp == 0) are deliberately classed as zero.
    function automatic fp_class_e fp16_classify(input fp16_t x);
        if (x.exp == '0) begin
            return CLS_ZERO;
        end
        if (x.exp == '1) begin
            return (x.frac == '0) ? CLS_INF : CLS_NAN;
        end
        return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/fp16_div_round.sv
// Normalises the raw quotient, rounds to nearest-even and packs the binary16 result,
// saturating to signed infinity or flushing to signed zero when the exponent leaves range.
module fp16_div_round
    import fp16_pkg::*;
(
    input  logic [QW-1:0]        q_i,
    input  logic                 r_nz_i,
    input  logic                 sign_i,
    input  logic signed [EW-1:0] exp_diff_i,
    output fp16_t                res_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    logic [MAN_W:0]        mant;
    logic [MAN_W-1:0]      frac_rnd;
    logic                  guard;
    logic                  sticky;
    logic                  dec;
    logic                  inc;
    logic                  carry;
    logic signed [EW-1:0]  e;

    always_comb begin
        mant   = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        dec    = 1'b0;
        if (q_i[QW-1]) begin
            mant   = q_i[QW-1:2];
            guard  = q_i[1];
            sticky = q_i[0] | r_nz_i;
        end else begin
            mant   = q_i[QW-2:1];
            guard  = q_i[0];
            sticky = r_nz_i;
            dec    = 1'b1;
        end

        // An all-ones mantissa rounding up wraps the fraction to zero and bumps the exponent.
        inc      = guard & (sticky | mant[0]);
        carry    = inc & (&mant);
        frac_rnd = mant[MAN_W-1:0] + MAN_W'(inc);
        e        = exp_diff_i - EW'(dec) + EW'(carry);

        res_o       = '{sign: sign_i, exp: '0, frac: '0};
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        if (e[EW-1] || (e == '0)) begin
            underflow_o = 1'b1;
        end else if (e[EW-2:0] >= (EW-1)'((1 << EXP_W) - 1)) begin
            res_o.exp  = '1;
            overflow_o = 1'b1;
        end else begin
            res_o.exp  = e[EXP_W-1:0];
            res_o.frac = frac_rnd;
        end
    end

endmodule

// File: rtl/fp16_div.sv
// Sequential binary16 divider: restoring mantissa division one quotient bit per cycle,
// with valid/ready handshakes on operand and result sides.
module fp16_div
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        div_by_zero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    state_e               state_q, state_d;
    logic                 sign_q, sign_d;
    logic signed [EW-1:0] exp_diff_q, exp_diff_d;
    logic [MAN_W:0]       mb_q, mb_d;
    logic [MAN_W+1:0]     r_q, r_d;
    logic [QW-1:0]        q_q, q_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 spec_q, spec_d;
    logic [15:0]          spec_res_q, spec_res_d;
    logic                 spec_inv_q, spec_inv_d;
    logic                 spec_dbz_q, spec_dbz_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [15:0]          result_q, result_d;
    logic                 dbz_q, dbz_d;
    logic                 inv_q, inv_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    fp16_t      fa, fb;
    fp_class_e  ca, cb;
    logic       sign_c;
    logic       spec_hit_c;
    logic [15:0] spec_val_c;
    logic       spec_inv_c;
    logic       spec_dbz_c;
    logic       r_ge_c;
    logic [MAN_W+1:0] r_sub_c;
    fp16_t      rnd_res;
    logic       rnd_ovf;
    logic       rnd_unf;

    assign fa     = a;
    assign fb     = b;
    assign ca     = fp16_classify(fa);
    assign cb     = fp16_classify(fb);
    assign sign_c = a[15] ^ b[15];

    // Special-operand detection in priority order; first match wins.
    always_comb begin
        spec_hit_c = 1'b1;
        spec_val_c = '0;
        spec_inv_c = 1'b0;
        spec_dbz_c = 1'b0;
        if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_ZERO && cb == CLS_ZERO) ||
            (ca == CLS_INF && cb == CLS_INF)) begin
            spec_val_c = FP16_QNAN;
            spec_inv_c = 1'b1;
        end else if (ca == CLS_INF) begin
            spec_val_c = {sign_c, FP16_INF[14:0]};
        end else if (cb == CLS_INF) begin
            spec_val_c = {sign_c, 15'b0};
        end else if (cb == CLS_ZERO) begin
            spec_val_c = {sign_c, FP16_INF[14:0]};
            spec_dbz_c = 1'b1;
        end else if (ca == CLS_ZERO) begin
            spec_val_c = {sign_c, 15'b0};
        end else begin
            spec_hit_c = 1'b0;
        end
    end

    assign r_ge_c  = (r_q >= {1'b0, mb_q});
    assign r_sub_c = r_ge_c ? (r_q - {1'b0, mb_q}) : r_q;

    fp16_div_round u_round (
        .q_i         (q_q),
        .r_nz_i      (|r_q),
        .sign_i      (sign_q),
        .exp_diff_i  (exp_diff_q),
        .res_o       (rnd_res),
        .overflow_o  (rnd_ovf),
        .underflow_o (rnd_unf)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_diff_d  = exp_diff_q;
        mb_d        = mb_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        spec_d      = spec_q;
        spec_res_d  = spec_res_q;
        spec_inv_d  = spec_inv_q;
        spec_dbz_d  = spec_dbz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        dbz_d       = dbz_q;
        inv_d       = inv_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d     = sign_c;
                    exp_diff_d = EW'(fa.exp) - EW'(fb.exp) + EW'(BIAS);
                    mb_d       = {1'b1, fb.frac};
                    r_d        = {2'b01, fa.frac};
                    q_d        = '0;
                    cnt_d      = CNT_W'(QW - 1);
                    spec_d     = spec_hit_c;
                    spec_res_d = spec_val_c;
                    spec_inv_d = spec_inv_c;
                    spec_dbz_d = spec_dbz_c;
                    in_ready_d = 1'b0;
                    result_d   = '0;
                    dbz_d      = 1'b0;
                    inv_d      = 1'b0;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                    state_d    = spec_hit_c ? NORM : DIV;
                end
            end
            DIV: begin
                q_d   = {q_q[QW-2:0], r_ge_c};
                r_d   = r_sub_c << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                out_valid_d = 1'b1;
                state_d     = DONE;
                if (spec_q) begin
                    result_d = spec_res_q;
                    inv_d    = spec_inv_q;
                    dbz_d    = spec_dbz_q;
                end else begin
                    result_d = rnd_res;
                    ovf_d    = rnd_ovf;
                    unf_d    = rnd_unf;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_diff_q  <= '0;
            mb_q        <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            spec_inv_q  <= 1'b0;
            spec_dbz_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            inv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_diff_q  <= exp_diff_d;
            mb_q        <= mb_d;
            r_q         <= r_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            spec_q      <= spec_d;
            spec_res_q  <= spec_res_d;
            spec_inv_q  <= spec_inv_d;
            spec_dbz_q  <= spec_dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            dbz_q       <= dbz_d;
            inv_q       <= inv_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign invalid     = inv_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: doc/fp16_div.md
Name: fp16_div

Overview:
- Sequential IEEE-754 binary16 divider: result = a / b.
- Companion to the multiplier datapath. The multiplier adds biased exponents (expA + expB − 15 + inc); this block subtracts them (expA − expB + 15 − dec).
- Uses an iterative restoring mantissa divider with a valid/ready handshake on both sides.
- Sits beside the multiplier in the FP unit and shares its exponent width and bias conventions.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored fraction width.
- BIAS, 15, exponent bias.
- QW, 13, quotient bits produced: weights 2^0 down to 2^-12.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  16  dividend, binary16.
- b  input  16  divisor, binary16.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  16  quotient, binary16.
- div_by_zero  output  1  finite nonzero / zero.
- invalid  output  1  0/0, inf/inf, or any NaN operand.
- overflow  output  1  result rounded to ±inf.
- underflow  output  1  result flushed to ±0.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0. Asserting rst mid-division aborts the operation; no result is produced.
- States: IDLE, DIV, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch sign=a[15]^b[15], exponents, and mantissas ma={1,fracA}, mb={1,fracB}.
  - Special case → DONE next cycle. Otherwise R=ma, count=QW−1, → DIV.
- Special-case priority (subnormal inputs, exp==0, are treated as zero):
  - Any NaN operand, 0/0, or inf/inf → 16'h7E00, invalid=1.
  - inf/x → signed inf, no flag.
  - x/inf → signed zero, no flag.
  - nonzero/0 → signed inf, div_by_zero=1.
  - 0/x → signed zero, no flag.
- DIV (exactly QW cycles), each cycle:
  - If R >= mb: q bit=1, R=R−mb; else q bit=0.
  - Then R=R<<1, with R 12 bits wide.
  - q fills MSB first. Leave DIV when count==0.
- NORM (1 cycle):
  - If q[12]=1: mant=q[12:2], guard=q[1], sticky=q[0]|(R!=0), dec=0.
  - Else: mant=q[11:1], guard=q[0], sticky=(R!=0), dec=1.
  - Round to nearest even: inc = guard & (sticky | mant[0]).
  - Mantissa carry-out → mant=1.0, exponent+1.
  - Exponent computed in 7-bit signed: e = expA − expB + BIAS − dec + carry.
  - e >= 31 → signed inf, overflow=1.
  - e <= 0 → signed zero, underflow=1 (no subnormal output).
- DONE:
  - out_valid=1; result and flags are registered and held stable until out_ready.
  - On out_valid & out_ready → IDLE. in_ready=1 the following cycle.
  - in_ready=0 in DIV, NORM, and DONE; in_valid is ignored there.
- Latency: accept edge N → out_valid high after edge N+QW+1 (normal path) or N+1 (special path). Throughput is one op per QW+3 cycles minimum.
- Flags are mutually exclusive. Flags and result are cleared when a new operand is accepted.

Decomposition:
- Shared package fp16_pkg holds:
  - EXP_W, MAN_W, BIAS.
  - Constants FP16_QNAN=16'h7E00, FP16_INF=16'h7C00.
  - The state enum.
  - An operand-classify function (zero/inf/nan/normal), reused by the multiplier.
- One combinational sub-module, fp16_div_round: takes q, R-nonzero, sign, and the exponent difference; produces the packed result plus overflow and underflow.

Test Plan:
- 3C00 / 3C00 → result 3C00, no flags, out_valid 14 cycles after accept (QW+1).
- 3C00 / 4200 (1/3) → 3555 (q[12]=0 path, dec=1, round-down). C600 / 4000 → C200 (sign).
- 3C00 / 0000 → 7C00, div_by_zero=1; 0000 / 0000 → 7E00, invalid=1; 7C00 / 7C00 → 7E00, invalid=1; each with out_valid 1 cycle after accept.
- 7BFF / 1400 → 7C00, overflow=1; 0400 / 4000 → 0000, underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles → result stable, in_ready=0, in_valid ignored. Then out_ready=1 → IDLE, and the next operand is accepted.
- Assert rst at DIV cycle 5 → out_valid=0 and in_ready=1 immediately. The next 4600 / 4000 → 4200.
